// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - serial register-file dump transmitter
// Purpose: when start is pulsed, walks register indices reg_first..reg_last,
//   wrapping from 15 to 0. It drives r_sel into the register_select mux,
//   snapshots each r_value, and shifts the snapshot out MSB-first on an
//   SPI-mode-0 style link.
// Optional feature: define REG_DUMP_PARITY_EN to append one even-parity bit
//   after each word's LSB. The parity bit is the XOR of the snapshot bits.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   start            1-cycle pulse that begins a dump; ignored unless idle
//   reg_first/last   inclusive 4-bit register index range
//   r_sel            register select out; bit 4 is always 0
//   r_value          selected register value, combinational from the mux
//   cs_n/sclk/sdo    serial frame select, clock (idles low), data
//   busy             high from the cycle after an accepted start until DONE exits
//   done             1-cycle pulse after the final bit period completes
module reg_dump_tx #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        reg_first,
  input  logic [3:0]        reg_last,
  output logic [4:0]        r_sel,
  input  logic [DATA_W-1:0] r_value,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

`ifdef REG_DUMP_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_LOAD, S_SHIFT, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [3:0]         last_q, last_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               sdo_q, sdo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NBITS-1:0]   load_word;

  // The parity bit rides at the bottom of the shift register, so the shift
  // path is identical with or without the feature.
`ifdef REG_DUMP_PARITY_EN
  assign load_word = {r_value, ^r_value};
`else
  assign load_word = r_value;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = reg_first;
          last_d  = reg_last;
          busy_d  = 1'b1;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        // r_sel has been stable for one cycle, so the mux output has settled.
        cs_n_d  = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = load_word;
        sdo_d   = load_word[NBITS-1];
        cnt_d   = CNT_W'(NBITS);
        div_d   = '0;
        sclk_d  = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // A high->low edge ends one bit period.
            if (cnt_q == CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = S_NEXT;
            end else begin
              shift_d = shift_q << 1;
              sdo_d   = shift_q[NBITS-2];
              cnt_d   = cnt_q - CNT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_NEXT: begin
        if (sel_q == last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + 4'd1;
          state_d = S_SELECT;
        end
      end
      S_DONE: begin
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        sdo_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign r_sel = {1'b0, sel_q};
  assign cs_n  = cs_n_q;
  assign sclk  = sclk_q;
  assign sdo   = sdo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb/tb_reg_dump_tx.sv - self-checking bench for reg_dump_tx
module tb_reg_dump_tx;
  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 32;
`ifdef REG_DUMP_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        reg_first = '0;
  logic [3:0]        reg_last = '0;
  logic [4:0]        r_sel;
  logic [DATA_W-1:0] r_value;
  logic              cs_n, sclk, sdo, busy, done;

  logic [31:0] regs [16];
  assign r_value = regs[r_sel[3:0]];

  reg_dump_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_first(reg_first),
    .reg_last(reg_last), .r_sel(r_sel), .r_value(r_value), .cs_n(cs_n),
    .sclk(sclk), .sdo(sdo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Wire-side observer: collects bits on sclk rising edges into words.
  logic [63:0] word_log [$];
  int          sel_log [$];
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          acc_n = 0;
  logic [63:0] acc = '0;

  initial begin
    logic sclk_prev;
    sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_n = 0;
        acc = '0;
        sclk_prev = 1'b0;
      end else begin
        if (sclk && !sclk_prev) begin
          if (acc_n == 0) sel_log.push_back(int'(r_sel));
          acc = {acc[62:0], sdo};
          acc_n++;
          rise_cnt++;
          if (acc_n == NBITS) begin
            word_log.push_back(acc);
            acc = '0;
            acc_n = 0;
          end
        end
        if (done) done_cnt++;
        sclk_prev = sclk;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wire_word(input logic [31:0] v);
`ifdef REG_DUMP_PARITY_EN
    return {31'd0, v, ^v};
`else
    return {32'd0, v};
`endif
  endfunction

  // Starts a dump of f..l and checks the whole frame against the expected
  // word list, which is computed from the register array at start time.
  task automatic dump_and_check(input string tag, input int f, input int l);
    logic [63:0] exp_w [$];
    int          exp_s [$];
    int          idx, w0, s0, d0, r0, n;
    bit          seen;
    idx = f;
    for (int k = 0; k < 16; k++) begin
      exp_s.push_back(idx);
      exp_w.push_back(wire_word(regs[idx]));
      if (idx == l) break;
      idx = (idx + 1) % 16;
    end
    w0 = word_log.size(); s0 = sel_log.size(); d0 = done_cnt; r0 = rise_cnt;
    @(negedge clk);
    start = 1'b1; reg_first = 4'(f); reg_last = 4'(l);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk({tag, " done_within_bound"}, 64'(seen), 64'd1);
    @(negedge clk);
    chk({tag, " cs_n_after"}, 64'(cs_n), 64'd1);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " done_single_cycle"}, 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, " done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, " word_count"}, 64'(word_log.size() - w0), 64'(exp_w.size()));
    chk({tag, " sclk_rises"}, 64'(rise_cnt - r0), 64'(exp_w.size() * NBITS));
    n = word_log.size() - w0;
    if (n > exp_w.size()) n = exp_w.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s word%0d", tag, k), word_log[w0 + k], exp_w[k]);
      chk($sformatf("%s rsel%0d", tag, k), 64'(sel_log[s0 + k]), 64'(exp_s[k]));
    end
  endtask

  initial begin
    int f, l, base;
    bit seen;
    for (int i = 0; i < 16; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_held cs_n", 64'(cs_n), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst cs_n", 64'(cs_n), 64'd1);
    chk("rst sclk", 64'(sclk), 64'd0);
    chk("rst sdo", 64'(sdo), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst r_sel", 64'(r_sel), 64'd0);

    // Single word.
    regs[5] = 32'hA5A5_0F0F;
    dump_and_check("single", 5, 5);

    // Ascending range.
    regs[1] = 32'd1; regs[2] = 32'd2; regs[3] = 32'd3;
    dump_and_check("range1_3", 1, 3);

    // Wrapping range through 15 and 0.
    regs[14] = 32'hE; regs[15] = 32'hF;
    dump_and_check("wrap14_1", 14, 1);

    // Snapshot isolation and ignored restart during a dump.
    regs[5] = 32'h1234_5678;
    fork
      dump_and_check("snapshot", 5, 5);
      begin
        repeat (40) @(negedge clk);
        regs[5] = 32'hFFFF_FFFF;
        repeat (10) @(negedge clk);
        start = 1'b1; reg_first = 4'd0; reg_last = 4'd15;
        @(negedge clk);
        start = 1'b0;
      end
    join
    base = word_log.size();
    repeat (20) @(negedge clk);
    chk("no_queued_start words", 64'(word_log.size()), 64'(base));
    chk("no_queued_start busy", 64'(busy), 64'd0);

    // Reset part-way through a word.
    regs[3] = $urandom;
    base = word_log.size();
    @(negedge clk);
    start = 1'b1; reg_first = 4'd3; reg_last = 4'd3;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (acc_n == 10) begin seen = 1'b1; break; end
    end
    chk("midreset reached_bit10", 64'(seen), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midreset cs_n", 64'(cs_n), 64'd1);
    chk("midreset sclk", 64'(sclk), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset r_sel", 64'(r_sel), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("midreset no_word", 64'(word_log.size()), 64'(base));

`ifdef REG_DUMP_PARITY_EN
    regs[2] = 32'h7;
    dump_and_check("parity", 2, 2);
    chk("parity bit33", 64'(word_log[word_log.size() - 1][0]), 64'd1);
`endif

    // Randomized ranges and contents.
    for (int t = 0; t < 4; t++) begin
      for (int i = 1; i < 16; i++) regs[i] = $urandom;
      f = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 15));
      dump_and_check($sformatf("rand%0d", t), f, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
